// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache-side request ports and the single main-memory port.
// The arbiter uses the slave view; whatever drives the caches and memory uses master.
interface mem_arbiter_if;
  logic [1:0]  c0_rw_flag;
  logic [31:0] c0_addr;
  logic [31:0] c0_write_data;
  logic [3:0]  c0_write_mask;
  logic [31:0] c0_read_data;
  logic        c0_busy;
  logic        c0_done;
  logic        c0_overflow;

  logic [1:0]  c1_rw_flag;
  logic [31:0] c1_addr;
  logic [31:0] c1_write_data;
  logic [3:0]  c1_write_mask;
  logic [31:0] c1_read_data;
  logic        c1_busy;
  logic        c1_done;
  logic        c1_overflow;

  logic [1:0]  mem_rw_flag;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_mask;
  logic [31:0] mem_read_data;
  logic        mem_busy;
  logic        mem_done;

  modport slave (
    input  c0_rw_flag, c0_addr, c0_write_data, c0_write_mask,
    output c0_read_data, c0_busy, c0_done, c0_overflow,
    input  c1_rw_flag, c1_addr, c1_write_data, c1_write_mask,
    output c1_read_data, c1_busy, c1_done, c1_overflow,
    output mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
    input  mem_read_data, mem_busy, mem_done
  );

  modport master (
    output c0_rw_flag, c0_addr, c0_write_data, c0_write_mask,
    input  c0_read_data, c0_busy, c0_done, c0_overflow,
    output c1_rw_flag, c1_addr, c1_write_data, c1_write_mask,
    input  c1_read_data, c1_busy, c1_done, c1_overflow,
    input  mem_rw_flag, mem_addr, mem_write_data, mem_write_mask,
    output mem_read_data, mem_busy, mem_done
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serializing two cache request streams onto one memory port,
// with a small FIFO per port and one outstanding memory transaction at a time.
module mem_arbiter #(
  parameter int QUEUE_BIT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  mem_arbiter_if.slave bus
);
  localparam int DEPTH = 1 << QUEUE_BIT;

  typedef struct packed {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } req_t;

  typedef enum logic {IDLE, ISSUED} state_e;

  req_t                 reqIn    [2];
  req_t                 portHead [2];
  req_t                 fifoMem_q [2][DEPTH];
  logic [QUEUE_BIT:0]   wrPtr_q  [2];
  logic [QUEUE_BIT:0]   rdPtr_q  [2];
  logic [1:0]           reqValid, fifoEmpty, fifoFull, portValid, push, pop, grantOh;
  logic [1:0]           overflow_q, done_q;
  logic [31:0]          readData_q [2];
  req_t                 memReq_q;
  state_e               state_q, state_d;
  logic                 owner_q, lastGrant_q, ownerRead_q;
  logic                 grant, issue, retire;

  always_comb begin
    reqIn[0] = {bus.c0_rw_flag, bus.c0_addr, bus.c0_write_data, bus.c0_write_mask};
    reqIn[1] = {bus.c1_rw_flag, bus.c1_addr, bus.c1_write_data, bus.c1_write_mask};
  end

  // An empty FIFO exposes the incoming request as its head so a fresh request
  // reaches memory on the very next cycle instead of waiting a cycle in the queue.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      reqValid[p]  = (reqIn[p].rw == 2'b01) || (reqIn[p].rw == 2'b10);
      fifoEmpty[p] = (wrPtr_q[p] == rdPtr_q[p]);
      fifoFull[p]  = (wrPtr_q[p][QUEUE_BIT] != rdPtr_q[p][QUEUE_BIT]) &&
                     (wrPtr_q[p][QUEUE_BIT-1:0] == rdPtr_q[p][QUEUE_BIT-1:0]);
      portValid[p] = !fifoEmpty[p] || reqValid[p];
      portHead[p]  = fifoEmpty[p] ? reqIn[p] : fifoMem_q[p][rdPtr_q[p][QUEUE_BIT-1:0]];
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    issue   = 1'b0;
    retire  = (state_q == ISSUED) && bus.mem_done;
    if (portValid[0] && portValid[1]) begin
      grant = ~lastGrant_q;
    end else begin
      grant = !portValid[0];
    end
    issue = (|portValid) && !bus.mem_busy && ((state_q == IDLE) || bus.mem_done);
    case (state_q)
      IDLE:    if (issue) state_d = ISSUED;
      ISSUED:  if (bus.mem_done && !issue) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    grantOh = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;
    for (int p = 0; p < 2; p++) begin
      pop[p]  = grantOh[p] && !fifoEmpty[p];
      push[p] = reqValid[p] && !fifoFull[p] && !(grantOh[p] && fifoEmpty[p]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < 2; p++) begin
        wrPtr_q[p] <= '0;
        rdPtr_q[p] <= '0;
      end
      overflow_q <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (push[p]) wrPtr_q[p] <= wrPtr_q[p] + 1'b1;
        if (pop[p])  rdPtr_q[p] <= rdPtr_q[p] + 1'b1;
        if (reqValid[p] && fifoFull[p]) overflow_q[p] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) fifoMem_q[p][wrPtr_q[p][QUEUE_BIT-1:0]] <= reqIn[p];
    end
  end

  // Completion is routed by the owner of the retiring transaction, which may
  // differ from the port granted in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      lastGrant_q   <= 1'b1;
      ownerRead_q   <= 1'b0;
      memReq_q      <= '0;
      done_q        <= '0;
      readData_q[0] <= '0;
      readData_q[1] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= retire ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
      if (retire && ownerRead_q) readData_q[owner_q] <= bus.mem_read_data;
      if (issue) begin
        owner_q     <= grant;
        lastGrant_q <= grant;
        ownerRead_q <= (portHead[grant].rw == 2'b01);
        memReq_q    <= portHead[grant];
      end else begin
        memReq_q <= '0;
      end
    end
  end

  assign bus.mem_rw_flag    = memReq_q.rw;
  assign bus.mem_addr       = memReq_q.addr;
  assign bus.mem_write_data = memReq_q.data;
  assign bus.mem_write_mask = memReq_q.mask;
  assign bus.c0_read_data   = readData_q[0];
  assign bus.c1_read_data   = readData_q[1];
  assign bus.c0_done        = done_q[0];
  assign bus.c1_done        = done_q[1];
  assign bus.c0_busy        = fifoFull[0];
  assign bus.c1_busy        = fifoFull[1];
  assign bus.c0_overflow    = overflow_q[0];
  assign bus.c1_overflow    = overflow_q[1];
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a zero-wait memory responder that answers
// every issue pulse with mem_done one cycle later.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int assertCount = 0;
  int failCount = 0;
  int c0DoneCount = 0;
  int c1DoneCount = 0;
  bit autoMem = 1'b1;
  bit pendDone = 1'b0;
  logic [31:0] pendData = '0;
  logic [31:0] issuedQ[$];
  int savedCount;
  logic [31:0] obs;

  always #5 clk = ~clk;

  mem_arbiter_if arbIf();

  mem_arbiter #(.QUEUE_BIT(1)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (arbIf)
  );

  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hDEAD_BEAF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic [1:0] rw, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
    if (port == 0) begin
      arbIf.c0_rw_flag = rw; arbIf.c0_addr = addr;
      arbIf.c0_write_data = data; arbIf.c0_write_mask = mask;
    end else begin
      arbIf.c1_rw_flag = rw; arbIf.c1_addr = addr;
      arbIf.c1_write_data = data; arbIf.c1_write_mask = mask;
    end
  endtask

  // Advance one cycle, then sample outputs and play the memory side.
  task automatic tick();
    @(posedge clk);
    #1;
    arbIf.c0_rw_flag = 2'b00;
    arbIf.c1_rw_flag = 2'b00;
    if (autoMem) begin
      arbIf.mem_done      = pendDone;
      arbIf.mem_read_data = pendDone ? pendData : 32'h0;
    end
    pendDone = (arbIf.mem_rw_flag != 2'b00);
    pendData = memData(arbIf.mem_addr);
    if (arbIf.mem_rw_flag != 2'b00) issuedQ.push_back(arbIf.mem_addr);
    if (arbIf.c0_done) c0DoneCount++;
    if (arbIf.c1_done) c1DoneCount++;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    autoMem = 1'b1;
    pendDone = 1'b0;
    arbIf.mem_done = 1'b0;
    arbIf.mem_busy = 1'b0;
    arbIf.mem_read_data = '0;
    applyStimulus(0, 2'b00, 32'h0, 32'h0, 4'h0);
    applyStimulus(1, 2'b00, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c0DoneCount = 0;
    c1DoneCount = 0;
    issuedQ.delete();
  endtask

  initial begin
    resetDut();
    checkOutput("rst_mem_rw", {30'b0, arbIf.mem_rw_flag}, 32'h0);
    checkOutput("rst_mem_addr", arbIf.mem_addr, 32'h0);
    checkOutput("rst_busy", {30'b0, arbIf.c1_busy, arbIf.c0_busy}, 32'h0);
    checkOutput("rst_done", {30'b0, arbIf.c1_done, arbIf.c0_done}, 32'h0);
    checkOutput("rst_ovf", {30'b0, arbIf.c1_overflow, arbIf.c0_overflow}, 32'h0);

    // Single read on port 0
    applyStimulus(0, 2'b01, 32'h40, 32'h0, 4'h0);
    tick();
    checkOutput("rd_issue_rw", {30'b0, arbIf.mem_rw_flag}, 32'h1);
    checkOutput("rd_issue_addr", arbIf.mem_addr, 32'h40);
    tick();
    checkOutput("rd_done_early", {31'b0, arbIf.c0_done}, 32'h0);
    tick();
    checkOutput("rd_done", {31'b0, arbIf.c0_done}, 32'h1);
    checkOutput("rd_data", arbIf.c0_read_data, 32'hDEAD_BEEF);
    checkOutput("rd_c1_done", {31'b0, arbIf.c1_done}, 32'h0);
    tick();
    checkOutput("rd_done_pulse", {31'b0, arbIf.c0_done}, 32'h0);

    // Simultaneous requests right after reset
    resetDut();
    applyStimulus(0, 2'b01, 32'h100, 32'h0, 4'h0);
    applyStimulus(1, 2'b10, 32'h200, 32'h1234_5678, 4'b0011);
    tick();
    checkOutput("sim_first_rw", {30'b0, arbIf.mem_rw_flag}, 32'h1);
    checkOutput("sim_first_addr", arbIf.mem_addr, 32'h100);
    tick();
    tick();
    checkOutput("sim_c0_done", {31'b0, arbIf.c0_done}, 32'h1);
    checkOutput("sim_c0_data", arbIf.c0_read_data, 32'hDEAD_BFAF);
    checkOutput("sim_second_rw", {30'b0, arbIf.mem_rw_flag}, 32'h2);
    checkOutput("sim_second_addr", arbIf.mem_addr, 32'h200);
    checkOutput("sim_second_wdata", arbIf.mem_write_data, 32'h1234_5678);
    checkOutput("sim_second_mask", {28'b0, arbIf.mem_write_mask}, 32'h3);
    tick();
    tick();
    checkOutput("sim_c1_done", {31'b0, arbIf.c1_done}, 32'h1);
    checkOutput("sim_c1_data", arbIf.c1_read_data, 32'h0);
    checkOutput("sim_c0_count", c0DoneCount, 32'd1);

    // Sustained contention: a new pair of reads every four cycles
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 2'b01, 32'h1000 + 4 * i, 32'h0, 4'h0);
      applyStimulus(1, 2'b01, 32'h2000 + 4 * i, 32'h0, 4'h0);
      repeat (4) tick();
    end
    repeat (4) tick();
    checkOutput("rr_issue_count", issuedQ.size(), 32'd8);
    for (int k = 0; k < 8; k++) begin
      obs = (k < issuedQ.size()) ? issuedQ[k] : 32'hFFFF_FFFF;
      checkOutput($sformatf("rr_order_%0d", k), obs, ((k % 2 == 0) ? 32'h1000 : 32'h2000) + 32'(4 * (k / 2)));
    end
    checkOutput("rr_c0_dones", c0DoneCount, 32'd4);
    checkOutput("rr_c1_dones", c1DoneCount, 32'd4);
    checkOutput("rr_ovf", {30'b0, arbIf.c1_overflow, arbIf.c0_overflow}, 32'h0);
    checkOutput("rr_c1_data", arbIf.c1_read_data, memData(32'h200C));

    // Memory busy for five cycles while port 0 queues three requests
    resetDut();
    arbIf.mem_busy = 1'b1;
    applyStimulus(0, 2'b01, 32'h300, 32'h0, 4'h0);
    tick();
    checkOutput("mb_busy_1", {31'b0, arbIf.c0_busy}, 32'h0);
    applyStimulus(0, 2'b01, 32'h304, 32'h0, 4'h0);
    tick();
    checkOutput("mb_busy_2", {31'b0, arbIf.c0_busy}, 32'h1);
    checkOutput("mb_ovf_2", {31'b0, arbIf.c0_overflow}, 32'h0);
    applyStimulus(0, 2'b01, 32'h308, 32'h0, 4'h0);
    tick();
    checkOutput("mb_ovf_3", {31'b0, arbIf.c0_overflow}, 32'h1);
    checkOutput("mb_no_issue", {30'b0, arbIf.mem_rw_flag}, 32'h0);
    tick();
    tick();
    arbIf.mem_busy = 1'b0;
    repeat (10) tick();
    checkOutput("mb_issue_count", issuedQ.size(), 32'd2);
    obs = (issuedQ.size() > 0) ? issuedQ[0] : 32'hFFFF_FFFF;
    checkOutput("mb_first", obs, 32'h300);
    obs = (issuedQ.size() > 1) ? issuedQ[1] : 32'hFFFF_FFFF;
    checkOutput("mb_second", obs, 32'h304);
    checkOutput("mb_dones", c0DoneCount, 32'd2);
    checkOutput("mb_data", arbIf.c0_read_data, memData(32'h304));
    checkOutput("mb_busy_end", {31'b0, arbIf.c0_busy}, 32'h0);

    // Reset while a read is outstanding; a late mem_done must be ignored
    applyStimulus(0, 2'b01, 32'h500, 32'h0, 4'h0);
    tick();
    checkOutput("ar_issued", {30'b0, arbIf.mem_rw_flag}, 32'h1);
    autoMem = 1'b0;
    pendDone = 1'b0;
    arbIf.mem_done = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_mem_rw", {30'b0, arbIf.mem_rw_flag}, 32'h0);
    checkOutput("ar_mem_addr", arbIf.mem_addr, 32'h0);
    checkOutput("ar_ovf", {31'b0, arbIf.c0_overflow}, 32'h0);
    checkOutput("ar_rdata", arbIf.c0_read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    savedCount = c0DoneCount + c1DoneCount;
    tick();
    arbIf.mem_done = 1'b1;
    arbIf.mem_read_data = 32'hCAFE_F00D;
    tick();
    arbIf.mem_done = 1'b0;
    checkOutput("ar_no_done", {30'b0, arbIf.c1_done, arbIf.c0_done}, 32'h0);
    tick();
    checkOutput("ar_no_done_2", {30'b0, arbIf.c1_done, arbIf.c0_done}, 32'h0);
    checkOutput("ar_done_count", c0DoneCount + c1DoneCount, savedCount);
    checkOutput("ar_rdata_kept", arbIf.c0_read_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
